tdpr_rr_arbiter: RTL and testbench
==================================

Name: tdpr_rr_arbiter

Overview:
- Shares the two ports of the team's true dual-port RAM (`True_DPR`) between NUM_REQ requesters.
- Each cycle, grants up to two requests in round-robin order. The first winner goes to port A, the second to port B.
- Defers any pair that would collide on one address, because the RAM's same-address cross-port behaviour is not usable.
- Drives the RAM control inputs from registers and returns read data to the originating requester with a valid strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_SIZE, 8, RAM address width; must match the RAM.
- DATA_SIZE, 8, RAM data width; must match the RAM.
- CNT_SIZE, 16, width of the collision statistics counter.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  request valid, one bit per requester.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_SIZE  address; requester i at [i*ADDR_SIZE +: ADDR_SIZE].
- req_din  in  NUM_REQ*DATA_SIZE  write data, packed the same way.
- gnt  out  NUM_REQ  combinational; request consumed this cycle.
- rd_valid  out  NUM_REQ  read data valid for requester i.
- rd_data  out  NUM_REQ*DATA_SIZE  read data per requester.
- en_a, we_a  out  1  RAM port A enable and write enable (registered).
- addr_a  out  ADDR_SIZE  RAM port A address (registered).
- din_a  out  DATA_SIZE  RAM port A write data (registered).
- dout_a  in  DATA_SIZE  RAM port A read data.
- en_b, we_b, addr_b, din_b, dout_b: same as port A, for port B.
- collision_cnt  out  CNT_SIZE  saturating count of deferred port-B candidates.

Behaviour:
- Reset values (asynchronous):
  - en_a/en_b/we_a/we_b = 0; addr_*/din_* = 0.
  - rd_valid = 0, rd_data = 0, collision_cnt = 0.
  - Round-robin pointer = 0; tag pipeline cleared.
- Selection, combinational in cycle t:
  - P = first asserted req scanning from the pointer upward, wrapping at NUM_REQ.
  - S = next asserted req after P, scanning the same way and stopping before wrapping back to P.
- Collision rule:
  - If addr(P) == addr(S) and (we(P) or we(S)), S is not granted.
  - Two reads of the same address are not a collision; both are granted.
- Grants:
  - gnt[P] = 1; gnt[S] = 1 unless deferred.
  - Each granted requester holds req and its fields stable until it sees gnt, then may present its next request on the following cycle.
  - No requester is ever granted twice in one cycle.
- Port drive (end of cycle t):
  - P is loaded into the A-registers; S, if granted, into the B-registers; an unused port gets en = 0.
  - The RAM samples at the end of cycle t+1.
- Read return:
  - A 2-stage tag pipeline (valid, requester index, port) per port returns the data.
  - In cycle t+2, rd_valid[i] = 1 for exactly one cycle and rd_data[i] = dout of the port used.
  - rd_valid stays 0 for writes.
  - rd_data[i] holds its last value when rd_valid[i] = 0.
  - Read latency from gnt to rd_valid is 2 cycles.
- Throughput: 2 accesses per cycle when there is no collision; back-to-back grants to the same requester are legal.
- Pointer update:
  - After any grant, pointer = (index of the last granted requester + 1) mod NUM_REQ.
  - With no grant, the pointer is unchanged.
  - A deferred S is therefore served as P (port A) next cycle at the latest, so there is no starvation.
- collision_cnt increments by 1 per deferral and saturates at all-ones.
- No req asserted: gnt = 0, both en = 0. The RAM then drives dout = Z, which is ignored because no tag is valid.
- Reset mid-operation: in-flight tags are discarded, so no rd_valid appears for reads issued before reset. Writes already on the RAM pins may or may not land.
- The arbiter never issues en=1 to both ports with equal addresses and any write enable set.

Decomposition:
- Shared package tdpr_pkg holds:
  - default ADDR_SIZE/DATA_SIZE;
  - PORT_A = 1'b0 and PORT_B = 1'b1 port encodings;
  - the tag record layout (valid, index, port).
- One sub-module, tdpr_rr_pick: a rotating find-first-set returning a one-hot grant and index from the request vector and start pointer.
  - Instantiate it twice: the second instance uses the request vector with P masked and start pointer P+1.

Test Plan:
- Single read: after reset, req[1]=1, we=0, addr=0x10 with RAM[0x10]=0xA5 → gnt[1] in the same cycle; en_a=1, addr_a=0x10 the next cycle; rd_valid[1]=1, rd_data[1]=0xA5 two cycles after gnt.
- Dual grant: req[0] writes 0x3C to addr 0x20 and req[2] reads addr 0x21 in the same cycle → gnt=0101; port A = write to 0x20, port B = read of 0x21; rd_valid[2] two cycles later; pointer = 3.
- Collision: req[0] writes 0x20 and req[1] reads 0x20 with pointer 0 → gnt=0001, collision_cnt=1; next cycle req[1] is granted on port A and returns the new value 0x3C.
- Fairness: all four requesters issue continuous reads to distinct addresses for 8 cycles → grants rotate {0,1},{2,3},{0,1},…; each requester gets 4 grants; no back-to-back unfairness.
- Same-address reads: req[2] and req[3] both read 0x40 → both granted; both rd_valid fire with the same data; collision_cnt unchanged.
- Reset mid-flight: assert rst one cycle after a read gnt → all outputs 0 immediately; no rd_valid ever appears for that read; the pointer restarts at 0.

Source files
------------

// File: rtl/tdpr_pkg.sv
// Shared definitions for the true-dual-port RAM round-robin arbiter.
// Holds default RAM geometry, port encodings and the read-return tag record.
// Requester indices are stored in IDX_W bits, enough for up to 8 requesters.
package tdpr_pkg;

    localparam int ADDR_SIZE_DEF = 8;
    localparam int DATA_SIZE_DEF = 8;
    localparam int IDX_W         = 3;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // One entry of the read-return pipeline: which requester gets which port's dout.
    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
        logic             port;
    } tag_t;

endpackage

// File: rtl/tdpr_rr_arbiter_if.sv
// Requester-side bundle of the arbiter: request fields in, grant and read return out.
// master = requesters (drive req/req_we/req_addr/req_din), slave = arbiter.
// Per-requester fields are packed flat, requester i at [i*WIDTH +: WIDTH].
interface tdpr_rr_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ-1:0]           req_we;
    logic [NUM_REQ*ADDR_SIZE-1:0] req_addr;
    logic [NUM_REQ*DATA_SIZE-1:0] req_din;
    logic [NUM_REQ-1:0]           gnt;
    logic [NUM_REQ-1:0]           rd_valid;
    logic [NUM_REQ*DATA_SIZE-1:0] rd_data;

    modport master (
        output req, req_we, req_addr, req_din,
        input  gnt, rd_valid, rd_data
    );

    modport slave (
        input  req, req_we, req_addr, req_din,
        output gnt, rd_valid, rd_data
    );
endinterface

// File: rtl/tdpr_rr_pick.sv
// Rotating find-first-set: first asserted bit of req at or above start, wrapping to bit 0.
// Ports: req (request vector), start (scan origin) -> found, onehot grant, idx of winner.
// Purely combinational; no state, no backpressure.
module tdpr_rr_pick
    import tdpr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        // First pass covers start..N-1; second pass only fires if that range was empty,
        // and then necessarily lands below start, which is the wrapped part of the scan.
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (IDX_W'(i) >= start)) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            onehot[i] = found && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/tdpr_rr_arbiter.sv
// Round-robin arbiter sharing both ports of a true dual-port RAM among NUM_REQ requesters.
// Latency: gnt combinational, RAM controls registered (+1), rd_valid/rd_data at gnt+2.
// Backpressure: a request waits (no gnt) until chosen; a same-address pair with a write defers S.
// Ports: clk/rst, rq (requester bundle), en/we/addr/din/dout per RAM port, collision_cnt.
module tdpr_rr_arbiter
    import tdpr_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    tdpr_rr_arbiter_if.slave     rq,
    output logic                 en_a,
    output logic                 we_a,
    output logic [ADDR_SIZE-1:0] addr_a,
    output logic [DATA_SIZE-1:0] din_a,
    input  logic [DATA_SIZE-1:0] dout_a,
    output logic                 en_b,
    output logic                 we_b,
    output logic [ADDR_SIZE-1:0] addr_b,
    output logic [DATA_SIZE-1:0] din_b,
    input  logic [DATA_SIZE-1:0] dout_b,
    output logic [CNT_SIZE-1:0]  collision_cnt
);

    logic [IDX_W-1:0]             ptr, ptr_nxt, s_start, last_idx;
    logic                         p_found, s_found, s_gnt, collide;
    logic [NUM_REQ-1:0]           p_oh, s_oh;
    logic [IDX_W-1:0]             p_idx, s_idx;
    logic                         we_p, we_s;
    logic [ADDR_SIZE-1:0]         addr_p, addr_s;
    logic [DATA_SIZE-1:0]         din_p, din_s;
    tag_t                         tag_a1, tag_a2, tag_b1, tag_b2;
    logic [NUM_REQ-1:0]           rd_valid_c;
    logic [NUM_REQ*DATA_SIZE-1:0] rd_data_c, rd_hold;

    tdpr_rr_pick #(.N(NUM_REQ)) u_pick_p (
        .req    (rq.req),
        .start  (ptr),
        .found  (p_found),
        .onehot (p_oh),
        .idx    (p_idx)
    );

    // Second winner: P removed, scan starts just after P so it never wraps back onto P.
    assign s_start = IDX_W'((int'(p_idx) + 1) % NUM_REQ);

    tdpr_rr_pick #(.N(NUM_REQ)) u_pick_s (
        .req    (rq.req & ~p_oh),
        .start  (s_start),
        .found  (s_found),
        .onehot (s_oh),
        .idx    (s_idx)
    );

    always_comb begin
        we_p   = 1'b0;
        we_s   = 1'b0;
        addr_p = '0;
        addr_s = '0;
        din_p  = '0;
        din_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (p_idx == IDX_W'(i)) begin
                we_p   = rq.req_we[i];
                addr_p = rq.req_addr[i*ADDR_SIZE +: ADDR_SIZE];
                din_p  = rq.req_din[i*DATA_SIZE +: DATA_SIZE];
            end
            if (s_idx == IDX_W'(i)) begin
                we_s   = rq.req_we[i];
                addr_s = rq.req_addr[i*ADDR_SIZE +: ADDR_SIZE];
                din_s  = rq.req_din[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // Same-address cross-port access is only safe when both sides read.
    assign collide  = p_found && s_found && (addr_p == addr_s) && (we_p || we_s);
    assign s_gnt    = s_found && !collide;
    assign rq.gnt   = (p_found ? p_oh : '0) | (s_gnt ? s_oh : '0);
    assign last_idx = s_gnt ? s_idx : p_idx;
    assign ptr_nxt  = p_found ? IDX_W'((int'(last_idx) + 1) % NUM_REQ) : ptr;

    // Read return: tag stage 2 lines up with the cycle the RAM presents dout.
    // rd_data is transparent on a hit and otherwise replays the held value.
    always_comb begin
        rd_valid_c = '0;
        rd_data_c  = rd_hold;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_a2.vld && tag_a2.idx == IDX_W'(i)) begin
                rd_valid_c[i]                     = 1'b1;
                rd_data_c[i*DATA_SIZE +: DATA_SIZE] = (tag_a2.port == PORT_A) ? dout_a : dout_b;
            end
            if (tag_b2.vld && tag_b2.idx == IDX_W'(i)) begin
                rd_valid_c[i]                     = 1'b1;
                rd_data_c[i*DATA_SIZE +: DATA_SIZE] = (tag_b2.port == PORT_A) ? dout_a : dout_b;
            end
        end
    end

    assign rq.rd_valid = rd_valid_c;
    assign rq.rd_data  = rd_data_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr           <= '0;
            en_a          <= 1'b0;
            we_a          <= 1'b0;
            addr_a        <= '0;
            din_a         <= '0;
            en_b          <= 1'b0;
            we_b          <= 1'b0;
            addr_b        <= '0;
            din_b         <= '0;
            tag_a1        <= '0;
            tag_a2        <= '0;
            tag_b1        <= '0;
            tag_b2        <= '0;
            collision_cnt <= '0;
            rd_hold       <= '0;
        end else begin
            ptr  <= ptr_nxt;
            en_a <= p_found;
            we_a <= p_found & we_p;
            if (p_found) begin
                addr_a <= addr_p;
                din_a  <= din_p;
            end
            en_b <= s_gnt;
            we_b <= s_gnt & we_s;
            if (s_gnt) begin
                addr_b <= addr_s;
                din_b  <= din_s;
            end
            tag_a1 <= '{vld: p_found & ~we_p, idx: p_idx, port: PORT_A};
            tag_b1 <= '{vld: s_gnt & ~we_s, idx: s_idx, port: PORT_B};
            tag_a2 <= tag_a1;
            tag_b2 <= tag_b1;
            if (collide && collision_cnt != '1) begin
                collision_cnt <= collision_cnt + CNT_SIZE'(1);
            end
            rd_hold <= rd_data_c;
        end
    end

endmodule

// File: tb/tb_tdpr_rr_arbiter.sv
// Directed self-checking bench for tdpr_rr_arbiter with a behavioural dual-port RAM.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1-3 units later.
// RAM contents default to ~addr, except 0x10=A5, 0x21=5A, 0x40=77.
module tb_tdpr_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, we_a, en_b, we_b;
    logic [7:0]  addr_a, din_a, addr_b, din_b;
    logic [7:0]  dout_a, dout_b;
    logic [15:0] collision_cnt;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int check_cnt = 0;
    int gcount [4];

    tdpr_rr_arbiter_if #(.NUM_REQ(4), .ADDR_SIZE(8), .DATA_SIZE(8)) rq ();

    tdpr_rr_arbiter #(.NUM_REQ(4), .ADDR_SIZE(8), .DATA_SIZE(8), .CNT_SIZE(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .rq            (rq.slave),
        .en_a          (en_a),
        .we_a          (we_a),
        .addr_a        (addr_a),
        .din_a         (din_a),
        .dout_a        (dout_a),
        .en_b          (en_b),
        .we_b          (we_b),
        .addr_b        (addr_b),
        .din_b         (din_b),
        .dout_b        (dout_b),
        .collision_cnt (collision_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read, one access per port per cycle.
    bit [7:0]   mem [256];
    bit [255:0] wr_mask;

    function automatic logic [7:0] init_val(logic [7:0] a);
        case (a)
            8'h10:   return 8'hA5;
            8'h21:   return 8'h5A;
            8'h40:   return 8'h77;
            default: return ~a;
        endcase
    endfunction

    always @(posedge clk) begin
        if (en_a) begin
            if (we_a) begin
                mem[addr_a]     <= din_a;
                wr_mask[addr_a] <= 1'b1;
            end else begin
                dout_a <= wr_mask[addr_a] ? mem[addr_a] : init_val(addr_a);
            end
        end
        if (en_b) begin
            if (we_b) begin
                mem[addr_b]     <= din_b;
                wr_mask[addr_b] <= 1'b1;
            end else begin
                dout_b <= wr_mask[addr_b] ? mem[addr_b] : init_val(addr_b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        rq.req      = '0;
        rq.req_we   = '0;
        rq.req_addr = '0;
        rq.req_din  = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [7:0] addr, input logic [7:0] din);
        rq.req[i]            = 1'b1;
        rq.req_we[i]         = we;
        rq.req_addr[i*8 +: 8] = addr;
        rq.req_din[i*8 +: 8]  = din;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_req();
        tick();
        tick();

        // Reset state
        chk("rst_en", {30'd0, en_a, en_b}, 32'd0);
        chk("rst_we", {30'd0, we_a, we_b}, 32'd0);
        chk("rst_addr", {16'd0, addr_a, addr_b}, 32'd0);
        chk("rst_din", {16'd0, din_a, din_b}, 32'd0);
        chk("rst_rd_valid", {28'd0, rq.rd_valid}, 32'd0);
        chk("rst_rd_data", rq.rd_data, 32'd0);
        chk("rst_cnt", {16'd0, collision_cnt}, 32'd0);
        rst = 1'b0;

        // Single read
        set_req(1, 1'b0, 8'h10, 8'h00);
        #1 chk("t1_gnt", {28'd0, rq.gnt}, 32'h2);
        tick();
        clear_req();
        chk("t1_port_a", {22'd0, en_a, we_a, addr_a}, {22'd0, 1'b1, 1'b0, 8'h10});
        chk("t1_en_b", {31'd0, en_b}, 32'd0);
        chk("t1_no_early_valid", {28'd0, rq.rd_valid}, 32'd0);
        tick();
        chk("t1_rd_valid", {28'd0, rq.rd_valid}, 32'h2);
        chk("t1_rd_data", {24'd0, rq.rd_data[15:8]}, 32'hA5);
        tick();
        chk("t1_valid_drop", {28'd0, rq.rd_valid}, 32'd0);
        chk("t1_data_hold", {24'd0, rq.rd_data[15:8]}, 32'hA5);
        chk("t1_idle_en", {30'd0, en_a, en_b}, 32'd0);

        // Collision: write and read of 0x20, pointer 0
        do_reset();
        set_req(0, 1'b1, 8'h20, 8'h3C);
        set_req(1, 1'b0, 8'h20, 8'h00);
        #1 chk("col_gnt", {28'd0, rq.gnt}, 32'h1);
        tick();
        rq.req[0] = 1'b0;
        #1 chk("col_retry_gnt", {28'd0, rq.gnt}, 32'h2);
        chk("col_cnt", {16'd0, collision_cnt}, 32'd1);
        chk("col_port_a_wr", {14'd0, en_a, we_a, addr_a, din_a}, {14'd0, 1'b1, 1'b1, 8'h20, 8'h3C});
        chk("col_en_b", {31'd0, en_b}, 32'd0);
        tick();
        clear_req();
        chk("col_port_a_rd", {22'd0, en_a, we_a, addr_a}, {22'd0, 1'b1, 1'b0, 8'h20});
        tick();
        chk("col_rd_valid", {28'd0, rq.rd_valid}, 32'h2);
        chk("col_rd_data", {24'd0, rq.rd_data[15:8]}, 32'h3C);
        tick();

        // Dual grant: write on A, read on B
        do_reset();
        set_req(0, 1'b1, 8'h20, 8'h3C);
        set_req(2, 1'b0, 8'h21, 8'h00);
        #1 chk("dual_gnt", {28'd0, rq.gnt}, 32'h5);
        tick();
        clear_req();
        chk("dual_port_a", {14'd0, en_a, we_a, addr_a, din_a}, {14'd0, 1'b1, 1'b1, 8'h20, 8'h3C});
        chk("dual_port_b", {22'd0, en_b, we_b, addr_b}, {22'd0, 1'b1, 1'b0, 8'h21});
        tick();
        chk("dual_rd_valid", {28'd0, rq.rd_valid}, 32'h4);
        chk("dual_rd_data", {24'd0, rq.rd_data[23:16]}, 32'h5A);
        // Pointer is now 3: requester 3 must win port A over requester 1
        set_req(1, 1'b0, 8'h11, 8'h00);
        set_req(3, 1'b0, 8'h13, 8'h00);
        #1 chk("ptr3_gnt", {28'd0, rq.gnt}, 32'hA);
        tick();
        clear_req();
        chk("ptr3_addrs", {16'd0, addr_a, addr_b}, {16'd0, 8'h13, 8'h11});
        tick();
        chk("ptr3_rd_valid", {28'd0, rq.rd_valid}, 32'hA);
        chk("ptr3_rd_data", {16'd0, rq.rd_data[31:24], rq.rd_data[15:8]}, {16'd0, 8'hEC, 8'hEE});
        tick();

        // Fairness: all four read continuously
        do_reset();
        for (int i = 0; i < 4; i++) begin
            gcount[i] = 0;
            set_req(i, 1'b0, 8'h80 + 8'(i), 8'h00);
        end
        for (int c = 0; c < 8; c++) begin
            #1 chk($sformatf("fair_gnt_%0d", c), {28'd0, rq.gnt}, (c % 2 == 0) ? 32'h3 : 32'hC);
            if (c >= 2) begin
                chk($sformatf("fair_rd_valid_%0d", c), {28'd0, rq.rd_valid}, (c % 2 == 0) ? 32'h3 : 32'hC);
            end
            for (int i = 0; i < 4; i++) begin
                if (rq.gnt[i]) gcount[i]++;
            end
            tick();
        end
        clear_req();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fair_count_%0d", i), gcount[i], 32'd4);
        end
        tick();
        tick();

        // Same-address reads (pointer 0 after the fairness run)
        set_req(2, 1'b0, 8'h40, 8'h00);
        set_req(3, 1'b0, 8'h40, 8'h00);
        #1 chk("same_gnt", {28'd0, rq.gnt}, 32'hC);
        tick();
        clear_req();
        chk("same_ports", {14'd0, en_a, en_b, addr_a, addr_b}, {14'd0, 1'b1, 1'b1, 8'h40, 8'h40});
        tick();
        chk("same_rd_valid", {28'd0, rq.rd_valid}, 32'hC);
        chk("same_rd_data", {16'd0, rq.rd_data[31:24], rq.rd_data[23:16]}, {16'd0, 8'h77, 8'h77});
        chk("same_cnt", {16'd0, collision_cnt}, 32'd0);
        tick();

        // Reset one cycle after a read grant
        set_req(1, 1'b0, 8'h10, 8'h00);
        #1 chk("rmf_gnt", {28'd0, rq.gnt}, 32'h2);
        tick();
        clear_req();
        #1 rst = 1'b1;
        #1 chk("rmf_en", {30'd0, en_a, en_b}, 32'd0);
        chk("rmf_addr", {16'd0, addr_a, addr_b}, 32'd0);
        chk("rmf_rd", {28'd0, rq.rd_valid}, 32'd0);
        chk("rmf_rd_data", rq.rd_data, 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("rmf_no_valid_%0d", c), {28'd0, rq.rd_valid}, 32'd0);
            tick();
        end
        // Pointer restarted at 0: requester 0 takes port A ahead of requester 3
        set_req(0, 1'b0, 8'h50, 8'h00);
        set_req(3, 1'b0, 8'h53, 8'h00);
        #1 chk("rmf_ptr_gnt", {28'd0, rq.gnt}, 32'h9);
        tick();
        clear_req();
        chk("rmf_ptr_addrs", {16'd0, addr_a, addr_b}, {16'd0, 8'h50, 8'h53});
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
